// File: rtl/seq_mult_shiftadd_if.sv
// ============================================================================
//  Module      : seq_mult_shiftadd_if
//  Description : Operand/product handshake bundle for seq_mult_shiftadd.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_mult_shiftadd_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 tc;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, tc, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, tc, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

`default_nettype wire

// File: rtl/seq_mult_shiftadd.sv
// ============================================================================
//  Module      : seq_mult_shiftadd
//  Description : Iterative WIDTH x WIDTH shift-and-add multiplier, one adder,
//                WIDTH iterations per product. Define SEQMUL_SIGNED_EN to add
//                a two's-complement mode selected per transaction by tc.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_mult_shiftadd #(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  seq_mult_shiftadd_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     r_mcand;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]     w_mcand_in;
  logic [WIDTH-1:0]     w_mplier_in;
  logic                 w_last;

  // Upper half accumulates partial sums; lower half holds the multiplier,
  // consumed LSB-first as the whole register shifts right.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
  end

  assign w_last = (r_cnt == CNT_W'(1));

`ifdef SEQMUL_SIGNED_EN
  logic r_neg;
  logic w_a_neg;
  logic w_b_neg;

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  assign w_a_neg     = bus.tc & bus.a[WIDTH-1];
  assign w_b_neg     = bus.tc & bus.b[WIDTH-1];
  assign w_mcand_in  = w_a_neg ? -bus.a : bus.a;
  assign w_mplier_in = w_b_neg ? -bus.b : bus.b;
  assign w_result    = r_neg ? -w_acc_nxt : w_acc_nxt;
`else
  logic w_unused_tc;

  assign w_unused_tc = bus.tc;
  assign w_mcand_in  = bus.a;
  assign w_mplier_in = bus.b;
  assign w_result    = w_acc_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_nxt = S_CALC;
      S_CALC:  if (w_last)        w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_product <= '0;
`ifdef SEQMUL_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_acc   <= {{WIDTH{1'b0}}, w_mplier_in};
            r_mcand <= w_mcand_in;
            r_cnt   <= CNT_W'(WIDTH);
`ifdef SEQMUL_SIGNED_EN
            r_neg   <= w_a_neg ^ w_b_neg;
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_product <= w_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_CALC) || (r_state == S_DONE);
  assign bus.product   = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_shiftadd.sv
// ============================================================================
//  Module      : tb_seq_mult_shiftadd
//  Description : Self-checking bench: vector table, corner sequences, random
//                traffic against an arithmetic model, plus a WIDTH=16 instance.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_mult_shiftadd;

  localparam int W = 8;
`ifdef SEQMUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  seq_mult_shiftadd_if #(.WIDTH(8))  bus8 ();
  seq_mult_shiftadd_if #(.WIDTH(16)) bus16 ();

  seq_mult_shiftadd #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  seq_mult_shiftadd #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [7:0]   a;
    logic [7:0]   b;
    logic         tc;
    logic [15:0]  expv;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Plain integer arithmetic on the operands as the user means them.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic tc);
    longint sa;
    longint sb;
    sa = longint'(a);
    sb = longint'(b);
    if (tc && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    return 16'(sa * sb);
  endfunction

  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic tc,
                      input int hold, input string tag, output logic [15:0] prod);
    int lat;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.tc = tc;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    for (int i = 0; i < 40 && !bus8.in_ready; i++) @(negedge clk);
    check({tag, " in_ready before accept"}, 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0; bus8.a = ~a; bus8.b = ~b;
    check({tag, " in_ready after accept"}, 64'(bus8.in_ready), 64'd0);
    check({tag, " busy in calc"}, 64'(bus8.busy), 64'd1);
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(W));
    prod = bus8.product;
    for (int i = 0; i < hold; i++) begin
      bus8.in_valid = 1'b1;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      @(negedge clk);
      check({tag, " out_valid held"}, 64'(bus8.out_valid), 64'd1);
      check({tag, " product stable"}, 64'(bus8.product), 64'(prod));
      check({tag, " in_ready in done"}, 64'(bus8.in_ready), 64'd0);
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check({tag, " out_valid cleared"}, 64'(bus8.out_valid), 64'd0);
    check({tag, " back to idle"}, 64'(bus8.in_ready), 64'd1);
    check({tag, " product kept in idle"}, 64'(bus8.product), 64'(prod));
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rt;
    int          lat;
    int          cyc;
    int          t_first;
    int          t_second;
    bit          saw_valid;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{"200x150",        8'd200, 8'd150, 1'b0, 16'h7530};
    vecs[1]  = '{"255x255",        8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[2]  = '{"0xAB",           8'h00,  8'hAB,  1'b0, 16'h0000};
    vecs[3]  = '{"7x9",            8'd7,   8'd9,   1'b0, 16'h003F};
    vecs[4]  = '{"tc -3x5",        8'hFD,  8'h05,  1'b1, SIGNED_EN ? 16'hFFF1 : 16'h04F1};
    vecs[5]  = '{"tc -128x-128",   8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[6]  = '{"u FDx05",        8'hFD,  8'h05,  1'b0, 16'h04F1};
    vecs[7]  = '{"u 80x80",        8'h80,  8'h80,  1'b0, 16'h4000};
    vecs[8]  = '{"tc 1x-1",        8'h01,  8'hFF,  1'b1, SIGNED_EN ? 16'hFFFF : 16'h00FF};
    vecs[9]  = '{"tc -1x-1",       8'hFF,  8'hFF,  1'b1, SIGNED_EN ? 16'h0001 : 16'hFE01};
    vecs[10] = '{"tc 127x-128",    8'h7F,  8'h80,  1'b1, SIGNED_EN ? 16'hC080 : 16'h3F80};

    reset = 1'b1;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.tc = 1'b0;  bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.tc = 1'b0; bus16.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(bus8.in_ready), 64'd1);
    check("reset out_valid", 64'(bus8.out_valid), 64'd0);
    check("reset busy", 64'(bus8.busy), 64'd0);
    check("reset product", 64'(bus8.product), 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      txn8(vecs[i].a, vecs[i].b, vecs[i].tc, 0, vecs[i].name, p);
      check({vecs[i].name, " product"}, 64'(p), 64'(vecs[i].expv));
    end

    // Consumer stalls in DONE while the producer keeps poking the inputs.
    txn8(8'd13, 8'd11, 1'b0, 5, "stall", p);
    check("stall product", 64'(p), 64'd143);

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    bus8.a = 8'd200; bus8.b = 8'd150; bus8.tc = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort in_ready", 64'(bus8.in_ready), 64'd1);
    check("abort busy", 64'(bus8.busy), 64'd0);
    check("abort out_valid", 64'(bus8.out_valid), 64'd0);
    check("abort product", 64'(bus8.product), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus8.out_valid) saw_valid = 1'b1;
    end
    check("abort no out_valid", 64'(saw_valid), 64'd0);
    txn8(8'd7, 8'd9, 1'b0, 0, "post-abort", p);
    check("post-abort product", 64'(p), 64'h003F);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rt = 1'($urandom);
      txn8(ra, rb, rt, int'($urandom_range(0, 2)), "random", p);
      check("random product", 64'(p), 64'(ref_mul(ra, rb, rt)));
    end

    // Wide instance: single product latency, then back-to-back issue spacing.
    @(negedge clk);
    bus16.a = 16'hFFFF; bus16.b = 16'h0002; bus16.tc = 1'b0;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    check("w16 in_ready", 64'(bus16.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("w16 latency", 64'(lat), 64'd16);
    check("w16 product", 64'(bus16.product), 64'h0001FFFE);
    @(negedge clk);
    bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    bus16.in_valid = 1'b1;
    cyc = 0; t_first = -1; t_second = -1;
    while (t_second < 0 && cyc < 100) begin
      if (bus16.in_ready) begin
        if (t_first < 0) t_first = cyc;
        else t_second = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    bus16.in_valid = 1'b0;
    check("w16 issue interval", 64'(t_second - t_first), 64'd18);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
